// File: rtl/fc_stream_mac.sv
// Streaming fully connected layer y = act(W*x) with runtime-loaded weights and P parallel MAC lanes.
// Define FC_STREAM_BIAS_EN to append M bias words to the weight stream and seed each accumulator with b[row].
module fc_stream_mac #(
   parameter int M    = 8,
   parameter int N    = 10,
   parameter int T    = 16,
   parameter int P    = 2,
   parameter int RELU = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         w_valid,
   output logic         w_ready,
   input  logic [T-1:0] w_data,
   input  logic         input_valid,
   output logic         input_ready,
   input  logic [T-1:0] input_data,
   output logic         output_valid,
   input  logic         output_ready,
   output logic [T-1:0] output_data
);

`ifdef FC_STREAM_BIAS_EN
   localparam int W_WORDS = M * N + M;
   localparam int BAW     = (M > 1) ? $clog2(M) : 1;
`else
   localparam int W_WORDS = M * N;
`endif
   localparam int G_NUM = M / P;
   localparam int WCW   = (W_WORDS > 1) ? $clog2(W_WORDS) : 1;
   localparam int WAW   = (M * N > 1) ? $clog2(M * N) : 1;
   localparam int XAW   = (N > 1) ? $clog2(N) : 1;
   localparam int SCW   = $clog2(N + 2);
   localparam int GCW   = (G_NUM > 1) ? $clog2(G_NUM) : 1;
   localparam int LCW   = (P > 1) ? $clog2(P) : 1;

   localparam logic signed [T-1:0] MAX_T = {1'b0, {(T-1){1'b1}}};
   localparam logic signed [T-1:0] MIN_T = {1'b1, {(T-1){1'b0}}};

   typedef enum logic [1:0] {S_LOAD_W, S_LOAD_X, S_COMPUTE, S_DRAIN} state_t;

   state_t               r_state;
   logic [WCW-1:0]       r_wcnt;
   logic [XAW-1:0]       r_xcnt;
   logic [SCW-1:0]       r_step;
   logic [GCW-1:0]       r_g;
   logic [LCW-1:0]       r_lane;
   logic [WAW-1:0]       r_wbase;
   logic                 r_wready;
   logic                 r_iready;
   logic                 r_ovalid;
   logic [T-1:0]         r_odata;
   logic signed [T-1:0]  r_acc  [P];
   logic [T-1:0]         r_obuf [P];

   logic signed [T-1:0]  r_wmem [M*N];
   logic signed [T-1:0]  r_xmem [N];
`ifdef FC_STREAM_BIAS_EN
   logic signed [T-1:0]  r_bmem [M];
`endif
   logic signed [T-1:0]  r_wrd  [P];
   logic signed [T-1:0]  r_xrd;

   logic [WAW-1:0]       w_raddr [P];
   logic signed [T-1:0]  w_init  [P];
   logic signed [T-1:0]  w_next  [P];
   logic                 w_w_hs;
   logic                 w_x_hs;
   logic                 w_o_hs;

   // Full 2T-bit product clamped back into T bits.
   function automatic logic signed [T-1:0] sat_mul(input logic signed [T-1:0] a,
                                                   input logic signed [T-1:0] b);
      logic signed [2*T-1:0] prod;
      prod = $signed({{T{a[T-1]}}, a}) * $signed({{T{b[T-1]}}, b});
      if (prod > $signed({{T{1'b0}}, MAX_T}))
         return MAX_T;
      else if (prod < $signed({{T{1'b1}}, MIN_T}))
         return MIN_T;
      else
         return prod[T-1:0];
   endfunction

   function automatic logic signed [T-1:0] sat_add(input logic signed [T-1:0] a,
                                                   input logic signed [T-1:0] b);
      logic [T:0] sum;
      sum = {a[T-1], a} + {b[T-1], b};
      if (sum[T] != sum[T-1])
         return sum[T] ? MIN_T : MAX_T;
      else
         return sum[T-1:0];
   endfunction

   function automatic logic [T-1:0] relu(input logic signed [T-1:0] v);
      if (RELU != 0 && v[T-1])
         return '0;
      else
         return v;
   endfunction

   assign w_w_hs       = w_valid && r_wready;
   assign w_x_hs       = input_valid && r_iready;
   assign w_o_hs       = r_ovalid && output_ready;
   assign w_ready      = r_wready;
   assign input_ready  = r_iready;
   assign output_valid = r_ovalid;
   assign output_data  = r_odata;

   // NOTE: every always_comb target gets a value on every path, so no latch is inferred.
   always_comb begin
      for (int p = 0; p < P; p++) begin
         w_raddr[p] = r_wbase + WAW'(p * N) + WAW'(r_step);
         w_next[p]  = sat_add(r_acc[p], sat_mul(r_wrd[p], r_xrd));
`ifdef FC_STREAM_BIAS_EN
         w_init[p]  = r_bmem[BAW'(int'(r_g) * P + p)];
`else
         w_init[p]  = '0;
`endif
      end
   end

   // NOTE: storage arrays have no reset; the FSM returning to LOAD_W is what invalidates them.
   always_ff @(posedge clk) begin
      if (w_w_hs) begin
`ifdef FC_STREAM_BIAS_EN
         if (int'(r_wcnt) < M * N)
            r_wmem[WAW'(r_wcnt)] <= w_data;
         else
            r_bmem[BAW'(int'(r_wcnt) - M * N)] <= w_data;
`else
         r_wmem[WAW'(r_wcnt)] <= w_data;
`endif
      end
      if (w_x_hs)
         r_xmem[r_xcnt] <= input_data;
      if (r_state == S_COMPUTE && r_step < SCW'(N)) begin
         for (int p = 0; p < P; p++)
            r_wrd[p] <= r_wmem[w_raddr[p]];
         r_xrd <= r_xmem[r_step[XAW-1:0]];
      end
   end

   // NOTE: all sequential state uses non-blocking assignment so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_LOAD_W;
         r_wcnt   <= '0;
         r_xcnt   <= '0;
         r_step   <= '0;
         r_g      <= '0;
         r_lane   <= '0;
         r_wbase  <= '0;
         r_wready <= 1'b1;
         r_iready <= 1'b0;
         r_ovalid <= 1'b0;
         r_odata  <= '0;
         for (int p = 0; p < P; p++) begin
            r_acc[p]  <= '0;
            r_obuf[p] <= '0;
         end
      end else begin
         case (r_state)
            S_LOAD_W: begin
               if (w_w_hs) begin
                  if (r_wcnt == WCW'(W_WORDS - 1)) begin
                     r_wcnt   <= '0;
                     r_wready <= 1'b0;
                     r_iready <= 1'b1;
                     r_state  <= S_LOAD_X;
                  end else begin
                     r_wcnt <= r_wcnt + WCW'(1);
                  end
               end
            end
            S_LOAD_X: begin
               if (w_x_hs) begin
                  if (r_xcnt == XAW'(N - 1)) begin
                     r_xcnt   <= '0;
                     r_iready <= 1'b0;
                     r_step   <= '0;
                     r_g      <= '0;
                     r_wbase  <= '0;
                     r_state  <= S_COMPUTE;
                  end else begin
                     r_xcnt <= r_xcnt + XAW'(1);
                  end
               end
            end
            S_COMPUTE: begin
               // Step 0 issues the first read, steps 1..N accumulate, step N+1 latches results.
               r_step <= r_step + SCW'(1);
               for (int p = 0; p < P; p++) begin
                  if (r_step == '0)
                     r_acc[p] <= w_init[p];
                  else if (r_step <= SCW'(N))
                     r_acc[p] <= w_next[p];
               end
               if (r_step == SCW'(N + 1)) begin
                  for (int p = 0; p < P; p++)
                     r_obuf[p] <= relu(r_acc[p]);
                  r_odata  <= relu(r_acc[0]);
                  r_ovalid <= 1'b1;
                  r_lane   <= '0;
                  r_step   <= '0;
                  r_state  <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (w_o_hs) begin
                  if (r_lane == LCW'(P - 1)) begin
                     r_ovalid <= 1'b0;
                     r_lane   <= '0;
                     if (r_g == GCW'(G_NUM - 1)) begin
                        r_g      <= '0;
                        r_wbase  <= '0;
                        r_iready <= 1'b1;
                        r_state  <= S_LOAD_X;
                     end else begin
                        r_g     <= r_g + GCW'(1);
                        r_wbase <= r_wbase + WAW'(P * N);
                        r_state <= S_COMPUTE;
                     end
                  end else begin
                     r_lane  <= r_lane + LCW'(1);
                     r_odata <= r_obuf[r_lane + LCW'(1)];
                  end
               end
            end
            default: r_state <= S_LOAD_W;
         endcase
      end
   end

endmodule

// File: tb/tb_fc_stream_mac.sv
// Self-checking bench for fc_stream_mac: a ReLU instance and a linear instance share all stimulus,
// and both are scored against a plain-arithmetic model of y = act(W*x) with saturation.
module tb_fc_stream_mac;

   localparam int M    = 8;
   localparam int N    = 10;
   localparam int T    = 16;
   localparam int P    = 2;
   localparam int MAXV = (1 << (T - 1)) - 1;
   localparam int MINV = -(1 << (T - 1));

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         w_valid = 1'b0;
   logic [T-1:0] w_data = '0;
   logic         input_valid = 1'b0;
   logic [T-1:0] input_data = '0;
   logic         output_ready = 1'b0;
   logic         w_ready, input_ready, output_valid;
   logic [T-1:0] output_data;
   logic         w_ready_l, input_ready_l, output_valid_l;
   logic [T-1:0] output_data_l;

   always #5 clk = ~clk;

   fc_stream_mac #(.M(M), .N(N), .T(T), .P(P), .RELU(1)) u_dut (
      .clk(clk), .reset(reset),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
      .input_valid(input_valid), .input_ready(input_ready), .input_data(input_data),
      .output_valid(output_valid), .output_ready(output_ready), .output_data(output_data)
   );

   fc_stream_mac #(.M(M), .N(N), .T(T), .P(P), .RELU(0)) u_dut_lin (
      .clk(clk), .reset(reset),
      .w_valid(w_valid), .w_ready(w_ready_l), .w_data(w_data),
      .input_valid(input_valid), .input_ready(input_ready_l), .input_data(input_data),
      .output_valid(output_valid_l), .output_ready(output_ready), .output_data(output_data_l)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int x_cnt = 0;
   int lat_cyc = 0;
   int oready_mode = 0;
   bit lat_wait = 0;
   bit loaded = 0;
   bit prev_hold = 0;
   bit rnd = 0;
   logic [T-1:0] prev_data = '0;

   int wm [M][N];
   int bm [M];
   int xv [N];
   logic [T-1:0] wq[$];
   logic [T-1:0] xq[$];
   logic [T-1:0] eq0[$];
   logic [T-1:0] eq1[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit coin();
      return $urandom_range(0, 1) == 1;
   endfunction

   function automatic logic [T-1:0] rnd_word();
      int unsigned u;
      u = $urandom;
      return u[T-1:0];
   endfunction

   function automatic int rnd_val();
      logic [T-1:0] s;
      case ($urandom_range(0, 3))
         0: begin s = rnd_word(); return int'($signed(s)); end
         1: return coin() ? MAXV : MINV;
         default: return int'($urandom_range(0, 600)) - 300;
      endcase
   endfunction

   function automatic longint clamp(input longint v);
      if (v > MAXV) return MAXV;
      if (v < MINV) return MINV;
      return v;
   endfunction

   // Golden row: saturate every product and every partial sum to T bits.
   function automatic int ref_row(input int m);
      longint acc;
`ifdef FC_STREAM_BIAS_EN
      acc = bm[m];
`else
      acc = 0;
`endif
      for (int n = 0; n < N; n++)
         acc = clamp(acc + clamp(longint'(wm[m][n]) * longint'(xv[n])));
      return int'(acc);
   endfunction

   function automatic logic [T-1:0] to_word(input int v);
      return v[T-1:0];
   endfunction

   // kind: 0 identity, 1 all max positive, 2 all -1, 3 random
   task automatic load_weights(input int kind);
      for (int m = 0; m < M; m++)
         for (int n = 0; n < N; n++) begin
            case (kind)
               0: wm[m][n] = (n == m) ? 1 : 0;
               1: wm[m][n] = MAXV;
               2: wm[m][n] = -1;
               default: wm[m][n] = rnd_val();
            endcase
            wq.push_back(to_word(wm[m][n]));
         end
      for (int m = 0; m < M; m++) begin
         bm[m] = (kind == 3) ? rnd_val() : m;
`ifdef FC_STREAM_BIAS_EN
         wq.push_back(to_word(bm[m]));
`endif
      end
   endtask

   // kind: 0 x=1..N, 1 all max positive, 2 all 3, 3 random
   task automatic push_vector(input int kind);
      int y;
      for (int n = 0; n < N; n++) begin
         case (kind)
            0: xv[n] = n + 1;
            1: xv[n] = MAXV;
            2: xv[n] = 3;
            default: xv[n] = rnd_val();
         endcase
         xq.push_back(to_word(xv[n]));
      end
      for (int m = 0; m < M; m++) begin
         y = ref_row(m);
         eq1.push_back(to_word(y));
         eq0.push_back(y < 0 ? '0 : to_word(y));
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      w_valid = 1'b0;
      input_valid = 1'b0;
      output_ready = 1'b0;
      @(posedge clk);
      cyc++;
      #1;
      reset = 1'b0;
      wq.delete();
      xq.delete();
      eq0.delete();
      eq1.delete();
      x_cnt = 0;
      lat_wait = 0;
      loaded = 0;
      prev_hold = 0;
   endtask

   // One clock: drive, check pre-edge observations, clock, then retire handshakes.
   task automatic step();
      logic pw, pi, po;
      logic [T-1:0] pd, pdl;
      if (wq.size() > 0) begin
         w_valid = rnd ? coin() : 1'b1;
         w_data  = wq[0];
      end else if (loaded) begin
         w_valid = 1'b1;
         w_data  = rnd_word();
      end else begin
         w_valid = 1'b0;
      end
      if (xq.size() > 0) begin
         input_valid = rnd ? coin() : 1'b1;
         input_data  = xq[0];
      end else begin
         input_valid = 1'b0;
      end
      case (oready_mode)
         0: output_ready = 1'b1;
         1: output_ready = coin();
         default: output_ready = 1'b0;
      endcase
      pw  = w_ready && w_ready_l;
      pi  = input_ready && input_ready_l;
      po  = output_valid && output_valid_l;
      pd  = output_data;
      pdl = output_data_l;
      if (prev_hold) begin
         check("hold_valid", po, 1);
         check("hold_data", pd, prev_data);
      end
      if (lat_wait && po) begin
         check("first_out_latency", cyc - lat_cyc, N + 2);
         lat_wait = 0;
      end
      if (po) check("in_ready_in_drain", pi, 0);
      if (loaded && wq.size() == 0) check("w_ready_after_load", pw, 0);
      @(posedge clk);
      cyc++;
      if (w_valid && pw && wq.size() > 0) begin
         void'(wq.pop_front());
         if (wq.size() == 0) loaded = 1;
      end
      if (input_valid && pi) begin
         void'(xq.pop_front());
         x_cnt++;
         if (x_cnt == N) begin
            x_cnt = 0;
            lat_wait = 1;
            lat_cyc = cyc;
         end
      end
      if (po && output_ready) begin
         check("out_pending", eq0.size() > 0, 1);
         if (eq0.size() > 0) begin
            check("y_relu", pd, eq0.pop_front());
            check("y_linear", pdl, eq1.pop_front());
         end
      end
      prev_hold = po && !output_ready;
      prev_data = pd;
      #1;
   endtask

   task automatic run_done(input string tag, input int budget);
      int i;
      i = 0;
      while ((wq.size() + xq.size() + eq0.size()) > 0 && i < budget) begin
         step();
         i++;
      end
      check(tag, wq.size() + xq.size() + eq0.size(), 0);
   endtask

   initial begin
      do_reset();
      check("rst_w_ready", w_ready, 1);
      check("rst_input_ready", input_ready, 0);
      check("rst_output_valid", output_valid, 0);
      check("rst_output_data", output_data, 0);

      // Identity weights; x is offered during LOAD_W and must wait.
      load_weights(0);
      push_vector(0);
      run_done("t1_identity_done", 2000);
      push_vector(3);
      run_done("t1_persist_done", 2000);

      do_reset();
      load_weights(1);
      push_vector(1);
      run_done("t2_saturate_done", 2000);

      do_reset();
      load_weights(2);
      push_vector(2);
      run_done("t3_negative_done", 2000);

      // Back-pressure for 20 cycles from the first output_valid.
      do_reset();
      load_weights(0);
      push_vector(0);
      oready_mode = 2;
      for (int i = 0; i < 300 && !prev_hold; i++) step();
      check("t4_stall_reached", prev_hold, 1);
      repeat (19) step();
      oready_mode = 0;
      run_done("t4_stall_done", 2000);

      // Reset in the fifth COMPUTE cycle, then reload and rerun.
      do_reset();
      load_weights(0);
      push_vector(0);
      for (int i = 0; i < 500 && (xq.size() > 0 || lat_wait == 0); i++) step();
      check("t5_in_compute", lat_wait, 1);
      repeat (4) step();
      do_reset();
      check("t5_output_valid", output_valid, 0);
      check("t5_input_ready", input_ready, 0);
      check("t5_w_ready", w_ready, 1);
      check("t5_output_data", output_data, 0);
      load_weights(0);
      push_vector(0);
      run_done("t5_reload_done", 2000);

      // Random handshakes on all three streams with random weights and vectors.
      do_reset();
      load_weights(3);
      rnd = 1;
      oready_mode = 1;
      repeat (500) push_vector(3);
      run_done("t6_random_done", 80000);
      rnd = 0;
      oready_mode = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
